// File: rtl/everloop_pkg.sv
// Shared types and helpers for the everloop frame sequencer: state encoding,
// frame size derivation, byte index width and the brightness scaling helper.
package everloop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_e;

    localparam int IDX_W = 8;

    function automatic int frame_bytes(input int num_leds, input int bytes_per_led);
        return num_leds * bytes_per_led;
    endfunction

    // Upper byte of the 8x8 product, so full brightness yields value-1 for nonzero data.
    function automatic logic [7:0] dim_byte(input logic [7:0] dat, input logic [7:0] bright);
        logic [15:0] prod;
        prod = {8'd0, dat} * {8'd0, bright};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/everloop_latch_timer.sv
// Loadable down-counter: after load_i, done_o is high on the CYCLES-th cycle,
// then the counter rests at zero until the next load.
module everloop_latch_timer #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic nrst,
    input  logic load_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/everloop_frame_ctrl.sv
// Everloop frame sequencer: fetches each frame byte from the active RAM bank,
// hands it to the serializer, holds the latch gap and swaps banks on commit.
// Optional brightness scaling is enabled by defining EVERLOOP_DIM_EN.
module everloop_frame_ctrl
    import everloop_pkg::*;
#(
    parameter int NUM_LEDS      = 35,
    parameter int BYTES_PER_LED = 4,
    parameter int ADR_W         = 11,
    parameter int BANK_STRIDE   = 256,
    parameter int LATCH_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable_i,
    input  logic             commit_i,
    output logic             commit_pending_o,
    output logic             active_bank_o,
    output logic             rd_en_o,
    output logic [ADR_W-1:0] rd_adr_o,
    input  logic             rd_ack_i,
    input  logic [7:0]       rd_dat_i,
`ifdef EVERLOOP_DIM_EN
    input  logic [7:0]       brightness_i,
`endif
    output logic             ser_valid_o,
    output logic [7:0]       ser_data_o,
    input  logic             ser_ready_i,
    output logic             ser_latch_o,
    output logic             frame_done_o
);

    localparam int               FRAME_BYTES = frame_bytes(NUM_LEDS, BYTES_PER_LED);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [ADR_W-1:0] BANK1_BASE  = ADR_W'(BANK_STRIDE);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             bank_q, bank_d;
    logic             pending_q, pending_d;
    logic             timer_load;
    logic             timer_done;
    logic [7:0]       cap_byte;

`ifdef EVERLOOP_DIM_EN
    assign cap_byte = dim_byte(rd_dat_i, brightness_i);
`else
    assign cap_byte = rd_dat_i;
`endif

    everloop_latch_timer #(
        .CYCLES (LATCH_CYCLES)
    ) u_latch_timer (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (timer_load),
        .done_o (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        bank_d       = bank_q;
        pending_d    = pending_q | commit_i;
        timer_load   = 1'b0;
        rd_en_o      = 1'b0;
        ser_valid_o  = 1'b0;
        ser_latch_o  = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_en_o = 1'b1;
                if (rd_ack_i) begin
                    data_d  = cap_byte;
                    state_d = SEND;
                end
            end
            SEND: begin
                ser_valid_o = 1'b1;
                if (ser_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        timer_load = 1'b1;
                        state_d    = LATCH;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = FETCH;
                    end
                end
            end
            LATCH: begin
                ser_latch_o = 1'b1;
                // Frame boundary: the only point where the bank may swap and enable is sampled.
                if (timer_done) begin
                    frame_done_o = 1'b1;
                    idx_d        = '0;
                    pending_d    = commit_i;
                    if (pending_q) begin
                        bank_d = ~bank_q;
                    end
                    state_d = enable_i ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            bank_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            bank_q    <= bank_d;
            pending_q <= pending_d;
        end
    end

    assign rd_adr_o         = (bank_q ? BANK1_BASE : '0) + ADR_W'(idx_q);
    assign ser_data_o       = data_q;
    assign active_bank_o    = bank_q;
    assign commit_pending_o = pending_q;

endmodule

// File: tb/tb_everloop_frame_ctrl.sv
// Self-checking bench for everloop_frame_ctrl: RAM and serializer responders,
// a frame-level reference model, a scenario table and directed corner sequences.
`timescale 1ns/1ps
module tb_everloop_frame_ctrl;

    localparam int FB     = 35 * 4;
    localparam int LC     = 10;
    localparam int STRIDE = 256;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable_i;
    logic        commit_i;
    logic        commit_pending_o;
    logic        active_bank_o;
    logic        rd_en_o;
    logic [10:0] rd_adr_o;
    logic        rd_ack_i;
    logic [7:0]  rd_dat_i;
    logic        ser_valid_o;
    logic [7:0]  ser_data_o;
    logic        ser_ready_i;
    logic        ser_latch_o;
    logic        frame_done_o;
`ifdef EVERLOOP_DIM_EN
    logic [7:0]  brightness_i = 8'd255;
`endif

    always #5 clk = ~clk;

    everloop_frame_ctrl dut (
        .clk              (clk),
        .nrst             (nrst),
        .enable_i         (enable_i),
        .commit_i         (commit_i),
        .commit_pending_o (commit_pending_o),
        .active_bank_o    (active_bank_o),
        .rd_en_o          (rd_en_o),
        .rd_adr_o         (rd_adr_o),
        .rd_ack_i         (rd_ack_i),
        .rd_dat_i         (rd_dat_i),
`ifdef EVERLOOP_DIM_EN
        .brightness_i     (brightness_i),
`endif
        .ser_valid_o      (ser_valid_o),
        .ser_data_o       (ser_data_o),
        .ser_ready_i      (ser_ready_i),
        .ser_latch_o      (ser_latch_o),
        .frame_done_o     (frame_done_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:2047];
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit ack_rand = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_byte(input int adr);
`ifdef EVERLOOP_DIM_EN
        return (int'(mem[adr]) * int'(brightness_i)) / 256;
`else
        return int'(mem[adr]);
`endif
    endfunction

    // RAM read port: ack after 1 (or random 1..3) cycles of rd_en_o.
    initial begin : ram_model
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        rd_ack_i = 1'b0;
        rd_dat_i = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            rd_ack_i = 1'b0;
            rd_dat_i = 8'($urandom);
            if (rd_en_o) begin
                if (cnt == 0) lat = ack_rand ? int'($urandom_range(1, 3)) : 1;
                if (cnt >= lat) begin
                    rd_ack_i = 1'b1;
                    rd_dat_i = mem[rd_adr_o];
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : ser_model
        ser_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ser_ready_i = 1'b1;
                1:       ser_ready_i = 1'($urandom_range(0, 1));
                default: ser_ready_i = 1'b0;
            endcase
        end
    end

    // Frame-level reference model, evaluated mid-cycle.
    int   byte_idx = 0;
    int   latch_run = 0;
    int   frames_done = 0;
    int   exp_data = 0;
    bit   model_bank = 1'b0;
    bit   model_pending = 1'b0;
    bit   model_idle = 1'b1;
    bit   prev_wait = 1'b0;
    int   prev_data = 0;
    int   hs_log [0:FB-1];

    always @(negedge clk) begin
        if (!nrst) begin
            byte_idx = 0;
            latch_run = 0;
            model_bank = 1'b0;
            model_pending = 1'b0;
            model_idle = 1'b1;
            prev_wait = 1'b0;
        end else begin
            chk("bank", int'(active_bank_o), int'(model_bank));
            chk("pending", int'(commit_pending_o), int'(model_pending));
            chk("strobe_excl", int'(rd_en_o) + int'(ser_valid_o) + int'(ser_latch_o) <= 1 ? 1 : 0, 1);
            if (model_idle)
                chk("idle_strobes", int'({rd_en_o, ser_valid_o, ser_latch_o, frame_done_o}), 0);
            if (prev_wait && ser_valid_o)
                chk("stall_data", int'(ser_data_o), prev_data);
            if (rd_en_o && rd_ack_i) begin
                chk("rd_adr", int'(rd_adr_o), (model_bank ? STRIDE : 0) + byte_idx);
                exp_data = exp_byte((model_bank ? STRIDE : 0) + byte_idx);
            end
            if (ser_valid_o && ser_ready_i) begin
                chk("ser_data", int'(ser_data_o), exp_data);
                chk("byte_in_frame", byte_idx < FB ? 1 : 0, 1);
                if (byte_idx < FB) hs_log[byte_idx] = int'(ser_data_o);
                byte_idx++;
            end
            prev_wait = ser_valid_o && !ser_ready_i;
            prev_data = int'(ser_data_o);
            if (ser_latch_o) begin
                latch_run++;
                chk("latch_len", latch_run <= LC ? 1 : 0, 1);
                chk("latch_after_frame", byte_idx, FB);
            end else begin
                latch_run = 0;
            end
            if (frame_done_o) begin
                chk("done_in_latch", int'(ser_latch_o), 1);
                chk("done_latch_run", latch_run, LC);
                chk("done_bytes", byte_idx, FB);
                frames_done++;
                byte_idx = 0;
                if (model_pending) model_bank = !model_bank;
                model_pending = commit_i;
                if (!enable_i) model_idle = 1'b1;
            end else begin
                if (commit_i) model_pending = 1'b1;
                if (model_idle && enable_i) model_idle = 1'b0;
            end
        end
    end

    task automatic wait_done();
        int start;
        int n;
        start = frames_done;
        n = 0;
        while (frames_done == start && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("done_wait", frames_done > start ? 1 : 0, 1);
    endtask

    task automatic wait_bytes(input int target);
        int n;
        n = 0;
        while (byte_idx < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("bytes_wait", byte_idx >= target ? 1 : 0, 1);
    endtask

    task automatic wait_rd_en();
        int n;
        n = 0;
        while (!rd_en_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rd_en_wait", int'(rd_en_o), 1);
    endtask

    task automatic pulse_commit();
        @(posedge clk);
        #1 commit_i = 1'b1;
        @(posedge clk);
        #1 commit_i = 1'b0;
    endtask

    typedef struct {
        int commit_byte;
        int ready_mode;
        bit ack_rand;
        int exp_bank;
        int exp_pending;
        int exp_adr;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int held;
        int n;
        vecs[0] = '{-1,  0, 1'b0, 0, 0, 0};
        vecs[1] = '{50,  0, 1'b0, 1, 0, 256};
        vecs[2] = '{-1,  1, 1'b1, 1, 0, 256};
        vecs[3] = '{0,   1, 1'b1, 0, 0, 0};
        vecs[4] = '{139, 1, 1'b0, 1, 0, 256};

        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < FB; i++) mem[i] = 8'(i);
`ifdef EVERLOOP_DIM_EN
        mem[3] = 8'd200;
        mem[STRIDE + 3] = 8'd200;
`endif
        enable_i = 1'b0;
        commit_i = 1'b0;
        nrst = 1'b1;
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(rd_en_o), 0);
        chk("rst_valid", int'(ser_valid_o), 0);
        chk("rst_latch", int'(ser_latch_o), 0);
        chk("rst_done", int'(frame_done_o), 0);
        chk("rst_bank", int'(active_bank_o), 0);
        chk("rst_pending", int'(commit_pending_o), 0);
        chk("rst_data", int'(ser_data_o), 0);
        chk("rst_adr", int'(rd_adr_o), 0);
        @(posedge clk);
        #2 nrst = 1'b1;
        enable_i = 1'b1;

        // Whole-frame scenarios
        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].ready_mode;
            ack_rand = vecs[v].ack_rand;
            if (vecs[v].commit_byte >= 0) begin
                wait_bytes(vecs[v].commit_byte);
                pulse_commit();
            end
            wait_done();
            #1;
            chk("vec_bank", int'(active_bank_o), vecs[v].exp_bank);
            chk("vec_pending", int'(commit_pending_o), vecs[v].exp_pending);
            wait_rd_en();
            chk("vec_next_adr", int'(rd_adr_o), vecs[v].exp_adr);
        end

        // Serializer stall of 20 cycles on byte 7 (bank 1 frame)
        ready_mode = 0;
        ack_rand = 1'b0;
        wait_bytes(7);
        ready_mode = 2;
        #1;
        n = 0;
        while (!ser_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", int'(ser_valid_o), 1);
        held = int'(ser_data_o);
        chk("stall_byte7", held, exp_byte(STRIDE + 7));
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", int'(ser_valid_o), 1);
            chk("stall_hold", int'(ser_data_o), held);
            chk("stall_no_rd", int'(rd_en_o), 0);
            @(posedge clk);
        end
        ready_mode = 0;
        #1;
        @(posedge clk);
        #1;
        chk("after_stall_rd_en", int'(rd_en_o), 1);
        chk("after_stall_adr", int'(rd_adr_o), STRIDE + 8);

        // Enable dropped mid-frame: frame completes, then idle
        wait_bytes(10);
        #1 enable_i = 1'b0;
        wait_done();
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("idle_quiet", int'({rd_en_o, ser_valid_o, ser_latch_o, frame_done_o}), 0);
            chk("idle_adr", int'(rd_adr_o), STRIDE);
            @(posedge clk);
            #1;
        end

        // Commit while idle: swap only at the end of the next frame
        pulse_commit();
        chk("idle_commit_pending", int'(commit_pending_o), 1);
        chk("idle_commit_bank", int'(active_bank_o), 1);
        enable_i = 1'b1;
        wait_rd_en();
        chk("restart_adr", int'(rd_adr_o), STRIDE);
        wait_done();
        #1;
        chk("idle_commit_swap", int'(active_bank_o), 0);
        chk("idle_commit_clear", int'(commit_pending_o), 0);

        // Commit coinciding with the swap cycle is retained
        pulse_commit();
        n = 0;
        while (latch_run != LC - 1 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1 commit_i = 1'b1;
        @(posedge clk);
        #1 commit_i = 1'b0;
        chk("swap_bank", int'(active_bank_o), 1);
        chk("swap_retain_pending", int'(commit_pending_o), 1);
        wait_done();
        #1;
        chk("second_swap_bank", int'(active_bank_o), 0);
        chk("second_swap_pending", int'(commit_pending_o), 0);

        // Randomized traffic with sporadic commits
        ready_mode = 1;
        ack_rand = 1'b1;
        begin
            int start;
            start = frames_done;
            n = 0;
            while (frames_done < start + 3 && n < 15000) begin
                @(posedge clk);
                #1 commit_i = ($urandom_range(0, 199) == 0);
                n++;
            end
            commit_i = 1'b0;
            chk("random_frames", frames_done >= start + 3 ? 1 : 0, 1);
        end

        // Async reset while stalled in SEND on bank 1 with a commit pending
        ready_mode = 0;
        ack_rand = 1'b0;
        wait_done();
        if (!model_bank) begin
            pulse_commit();
            wait_done();
        end
        pulse_commit();
        ready_mode = 2;
        #1;
        n = 0;
        while (!ser_valid_o && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_reset_send", int'(ser_valid_o), 1);
        chk("pre_reset_bank", int'(active_bank_o), 1);
        @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        chk("arst_valid", int'(ser_valid_o), 0);
        chk("arst_rd_en", int'(rd_en_o), 0);
        chk("arst_latch", int'(ser_latch_o), 0);
        chk("arst_done", int'(frame_done_o), 0);
        chk("arst_bank", int'(active_bank_o), 0);
        chk("arst_pending", int'(commit_pending_o), 0);
        chk("arst_data", int'(ser_data_o), 0);
        chk("arst_adr", int'(rd_adr_o), 0);
        ready_mode = 0;
        @(posedge clk);
        #2 nrst = 1'b1;
        wait_rd_en();
        chk("post_reset_adr", int'(rd_adr_o), 0);
        wait_done();

`ifdef EVERLOOP_DIM_EN
        #1 brightness_i = 8'd128;
        wait_bytes(4);
        chk("dim_128", hs_log[3], 100);
        wait_done();
        #1 brightness_i = 8'd0;
        wait_bytes(4);
        chk("dim_0", hs_log[3], 0);
        wait_done();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/everloop_frame_ctrl.md
Name: everloop_frame_ctrl

Overview:
Frame sequencer for the everloop LED chain. It walks the 140-byte pixel frame (35 LEDs x 4 bytes) in a double-banked frame RAM and hands each byte to the serializer over a valid/ready handshake. After each frame it holds the chain-latch gap, then swaps banks on a host commit. It sits between the Wishbone-written everloop RAM read port and the serializer, replacing the free-running address counter.

Parameters:
NUM_LEDS, 35, LEDs in chain
BYTES_PER_LED, 4, bytes per LED
ADR_W, 11, frame RAM address width
BANK_STRIDE, 256, address offset of bank 1 (bank 0 base = 0)
LATCH_CYCLES, 10, clk cycles ser_latch_o held high between frames (>=1)

Ports:
clk  in  1  system clock
nrst  in  1  reset; asynchronous, active-low
enable_i  in  1  run frames; sampled only at frame boundaries
commit_i  in  1  one-cycle pulse: host finished writing inactive bank
commit_pending_o  out  1  commit accepted, swap not yet done
active_bank_o  out  1  bank being displayed
rd_en_o  out  1  RAM read request
rd_adr_o  out  ADR_W  RAM read address
rd_ack_i  in  1  RAM read data valid
rd_dat_i  in  8  RAM read data
ser_valid_o  out  1  byte available to serializer
ser_data_o  out  8  byte to serializer
ser_ready_i  in  1  serializer accepts byte
ser_latch_o  out  1  chain reset/latch request to serializer
frame_done_o  out  1  one-cycle pulse at end of latch gap

Behaviour:
- Reset (nrst low, async): state IDLE. All outputs 0: bank 0, pending 0, byte index 0.
- FRAME_BYTES = NUM_LEDS*BYTES_PER_LED. Byte index is 8 bits.
- rd_adr_o = (active_bank_o ? BANK_STRIDE : 0) + idx, zero-extended to ADR_W.
- IDLE: all strobes low. If enable_i is high, set idx=0 and go to FETCH next cycle.
- FETCH: rd_en_o=1 and rd_adr_o stable until rd_ack_i. On the ack cycle:
  - register rd_dat_i into ser_data_o;
  - drop rd_en_o;
  - go to SEND.
  - No timeout; rd_en_o stays high indefinitely without an ack.
- SEND: ser_valid_o=1. ser_data_o is held stable until ser_ready_i is high in the same cycle as valid.
  - On that handshake: ser_valid_o drops next cycle.
  - If idx==FRAME_BYTES-1, go to LATCH. Otherwise idx+1 and go to FETCH.
  - Minimum 2 cycles per byte.
- LATCH: ser_latch_o=1 for exactly LATCH_CYCLES cycles. On the last cycle:
  - frame_done_o=1;
  - if commit_pending_o, toggle active_bank_o and clear pending;
  - idx=0;
  - next state FETCH if enable_i, else IDLE.
- Commit rules:
  - commit_i sets commit_pending_o the next cycle.
  - Repeated commits while pending have no further effect.
  - A commit in the same cycle as the swap is retained: pending stays 1 for the next frame.
  - Commit in IDLE: the swap happens at the end of the next frame's latch gap, never mid-frame.
- enable_i deasserted mid-frame: the frame and latch gap complete, then the block idles. A frame is never truncated.
- Bank never changes while idx>0 or in FETCH/SEND. A frame is always read from one bank.
- Reset mid-frame: immediate return to IDLE with outputs 0. The serializer handles the partial byte.

Optional Feature:
EVERLOOP_DIM_EN
- Defined: adds input brightness_i[7:0]. Captured byte = (rd_dat_i*brightness_i)>>8, computed in the FETCH ack cycle with no added latency. brightness_i is sampled per byte; 255 gives value-1 for nonzero input, 0 gives 0.
- Undefined: no port; ser_data_o = rd_dat_i exactly.

Decomposition:
- Package everloop_pkg:
  - state encoding IDLE/FETCH/SEND/LATCH (2 bits);
  - FRAME_BYTES derivation;
  - byte index width constant.
- One sub-module, everloop_latch_timer: load/count-down of LATCH_CYCLES with a done pulse. Also reusable by the serializer.

Test Plan:
- Bank 0 bytes 0..139 = index, enable_i=1, rd_ack_i one cycle after rd_en_o, ser_ready_i always 1 -> ser_data_o sequence 0..139; ser_latch_o high 10 cycles; frame_done_o one pulse; next frame starts at address 0.
- commit_i pulsed at byte 50 of frame -> commit_pending_o=1 through byte 139; active_bank_o flips on frame_done_o cycle; next frame addresses 256..395.
- ser_ready_i held low 20 cycles on byte 7 -> ser_valid_o and ser_data_o stable all 20 cycles; no rd_en_o during stall; byte 8 fetched after handshake.
- enable_i dropped at byte 10 -> bytes 11..139 and latch gap still emitted, then IDLE with all strobes 0; re-enable restarts at idx 0.
- nrst pulsed low asynchronously mid-SEND -> all outputs 0 in the same cycle; commit_pending_o cleared; bank 0.
- EVERLOOP_DIM_EN: rd_dat_i=200, brightness_i=128 -> ser_data_o=100; brightness_i=0 -> 0.
